mem_input_writer: RTL and testbench
===================================

// Module: mem_input_writer
// PURPOSE
//   Consumes touchscreen entries from lcd_module (input_valid/input_value) and turns them into
//   memory write transactions into the central debug write port. Each address entry is
//   followed by a data entry, then a write handshake is issued.
//   Sits beside cpu_display, on the input path of the screen interface (display is the output path).
//   Optional auto-increment supports burst loading of consecutive words.
// PARAMETERS
//   ADDR_W      5    width of memory word address
//   DATA_W      32   width of write data (== input_value width)
//   AUTO_INC    1    1: after a write, stay in data phase with addr+1; 0: return to address phase
//   WR_TIMEOUT  255  max cycles wr_en waits for wr_ready before abort (>=1)
// PORTS
//   clk          in   1       system clock (10 MHz, shared with lcd_module)
//   reset        in   1       synchronous, active-high reset
//   input_valid  in   1       lcd_module entry-valid level; one entry per rising edge
//   input_value  in   DATA_W  lcd_module entered value, stable while input_valid high
//   wr_en        out  1       write request, held until accepted or timeout
//   wr_addr      out  ADDR_W  write address, stable while wr_en high
//   wr_data      out  DATA_W  write data, stable while wr_en high
//   wr_ready     in   1       write accepted this cycle when wr_en & wr_ready
//   phase        out  2       0=ADDR, 1=DATA, 2=WRITE (state, for display block)
//   cur_addr     out  ADDR_W  address the next data entry will write
//   write_count  out  8       completed writes, wraps 255->0
//   err_range    out  1       sticky: address entry exceeded ADDR_W bits
//   err_overrun  out  1       sticky: entry arrived during WRITE and was dropped
//   err_timeout  out  1       sticky: write aborted after WR_TIMEOUT cycles
// BEHAVIOUR
//   - All outputs registered. Reset: state=ADDR, wr_en=0, wr_addr=0, wr_data=0, cur_addr=0,
//     write_count=0, all err_*=0, edge register=0. Reset mid-WRITE drops wr_en next edge, no write counted.
//   - Entry detect: accept = input_valid & ~input_valid_q (input_valid_q registered each cycle).
//     Held-high input_valid yields exactly one entry.
//   - ADDR: on accept, if input_value[DATA_W-1:ADDR_W]!=0 -> set err_range, stay ADDR,
//     cur_addr unchanged. Else cur_addr<=input_value[ADDR_W-1:0], -> DATA.
//   - DATA: on accept, wr_data<=input_value, wr_addr<=cur_addr, wr_en<=1, tmo_cnt<=0, -> WRITE.
//     wr_en is visible the cycle after the accept edge (latency 1).
//   - WRITE: if wr_en & wr_ready: wr_en<=0, write_count<=write_count+1;
//     AUTO_INC=1: cur_addr<=cur_addr+1 (wraps max->0), -> DATA; AUTO_INC=0: -> ADDR.
//     Else tmo_cnt+1; when tmo_cnt==WR_TIMEOUT-1 with no ready: wr_en<=0, err_timeout<=1, -> ADDR,
//     count and cur_addr unchanged. wr_ready outside WRITE ignored.
//   - Accept during WRITE: entry dropped, err_overrun<=1; a ready in the same cycle still completes.
//   - err_* flags clear only on reset. Other flags never block operation.
//   - phase mirrors state encoding, updated on the same edge as the state.
// TESTING
//   1 reset; ADDR entry 0x3, DATA entry 0xDEADBEEF, wr_ready tied 1 -> wr_en high 1 cycle,
//     wr_addr=3, wr_data=0xDEADBEEF, write_count=1, phase=DATA, cur_addr=4.
//   2 AUTO_INC=1 burst: ADDR 0x1E, data 0xA,0xB,0xC -> writes at 0x1E,0x1F,0x00 (wrap), write_count=3.
//   3 ADDR entry 0x20 -> err_range=1, phase stays 0; next ADDR 0x05 -> phase=1, cur_addr=5.
//   4 wr_ready held 0, WR_TIMEOUT=4 -> wr_en high exactly 4 cycles, then err_timeout=1, phase=0,
//     write_count unchanged.
//   5 input_valid held high 10 cycles in ADDR -> exactly one entry; new edge in WRITE
//     (ready held 0) -> err_overrun=1, data unchanged.
//   6 assert reset in the cycle after wr_en rises -> next cycle wr_en=0, phase=0, all counters 0.

Source files
------------

// File: rtl/mem_input_writer.sv
// Turns touchscreen entries (address, then data) into handshaked write transactions
// on the debug write port, with optional address auto-increment for burst loading.
module mem_input_writer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter bit AUTO_INC   = 1'b1,
    parameter int WR_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              input_valid,
    input  logic [DATA_W-1:0] input_value,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic [1:0]        phase,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [7:0]        write_count,
    output logic              err_range,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int              TMO_W    = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ADDR  = 2'd0,
        ST_DATA  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              input_valid_q;
    logic              accept;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n, cur_addr_n;
    logic [DATA_W-1:0] wr_data_n;
    logic [7:0]        write_count_n;
    logic              err_range_n, err_overrun_n, err_timeout_n;

    // A held-high input_valid counts as a single entry: only its rising edge is accepted.
    assign accept = input_valid & ~input_valid_q;
    assign phase  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_ADDR;
            input_valid_q <= 1'b0;
            tmo_cnt       <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            cur_addr      <= '0;
            write_count   <= '0;
            err_range     <= 1'b0;
            err_overrun   <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_n;
            input_valid_q <= input_valid;
            tmo_cnt       <= tmo_cnt_n;
            wr_en         <= wr_en_n;
            wr_addr       <= wr_addr_n;
            wr_data       <= wr_data_n;
            cur_addr      <= cur_addr_n;
            write_count   <= write_count_n;
            err_range     <= err_range_n;
            err_overrun   <= err_overrun_n;
            err_timeout   <= err_timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        tmo_cnt_n     = tmo_cnt;
        wr_en_n       = wr_en;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        cur_addr_n    = cur_addr;
        write_count_n = write_count;
        err_range_n   = err_range;
        err_overrun_n = err_overrun;
        err_timeout_n = err_timeout;

        case (state)
            ST_ADDR: begin
                if (accept) begin
                    if ((input_value >> ADDR_W) != '0) begin
                        err_range_n = 1'b1;
                    end else begin
                        cur_addr_n = input_value[ADDR_W-1:0];
                        state_n    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_data_n = input_value;
                    wr_addr_n = cur_addr;
                    wr_en_n   = 1'b1;
                    tmo_cnt_n = '0;
                    state_n   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Entries cannot be queued behind an outstanding write; they are dropped and flagged.
                if (accept) begin
                    err_overrun_n = 1'b1;
                end
                if (wr_en && wr_ready) begin
                    wr_en_n       = 1'b0;
                    write_count_n = write_count + 8'd1;
                    if (AUTO_INC) begin
                        cur_addr_n = cur_addr + ADDR_W'(1);
                        state_n    = ST_DATA;
                    end else begin
                        state_n    = ST_ADDR;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    wr_en_n       = 1'b0;
                    err_timeout_n = 1'b1;
                    state_n       = ST_ADDR;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                wr_en_n = 1'b0;
                state_n = ST_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_input_writer.sv
// Directed-plus-random bench for mem_input_writer; expected writes come from a simple
// address/data queue model of the entry sequence rather than from the DUT.
`timescale 1ns/1ps
module tb_mem_input_writer;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int WR_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              input_valid;
    logic [DATA_W-1:0] input_value;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [1:0]        phase;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        write_count;
    logic              err_range, err_overrun, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] got_writes[$];
    logic [ADDR_W+DATA_W-1:0] exp_writes[$];
    int                       wr_en_cycles = 0;

    int                exp_count;
    int                exp_cur;
    logic [DATA_W-1:0] d, d2;
    logic [DATA_W-1:0] burst_vals[3];

    mem_input_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_INC(1'b1), .WR_TIMEOUT(WR_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_value(input_value),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .phase(phase), .cur_addr(cur_addr), .write_count(write_count),
        .err_range(err_range), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #50 clk = ~clk;

    // Handshakes are observed mid-cycle, where wr_en/wr_ready are stable ahead of the accepting edge.
    always @(negedge clk) begin
        if (wr_en) wr_en_cycles++;
        if (wr_en && wr_ready && !reset) got_writes.push_back({wr_addr, wr_data});
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clean entry: a single-cycle valid pulse, then one idle cycle so the next entry is a new edge.
    task automatic applyStimulus(input logic [DATA_W-1:0] value);
        input_valid = 1'b1;
        input_value = value;
        tick();
        input_valid = 1'b0;
        tick();
    endtask

    task automatic waitWriteIdle(input int max_cycles);
        int k = 0;
        while (wr_en && k < max_cycles) begin
            tick();
            k++;
        end
        checkOutput("wr_en_drop_bound", 32'(wr_en), 32'd0);
    endtask

    task automatic modelWrite(input logic [DATA_W-1:0] value);
        exp_writes.push_back({ADDR_W'(exp_cur), value});
        exp_cur   = (exp_cur + 1) % (1 << ADDR_W);
        exp_count = (exp_count + 1) % 256;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(got_writes.size()), 32'(exp_writes.size()));
        for (int i = 0; i < got_writes.size() && i < exp_writes.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(got_writes[i][ADDR_W+DATA_W-1:DATA_W]),
                        32'(exp_writes[i][ADDR_W+DATA_W-1:DATA_W]));
            checkOutput($sformatf("%s_data%0d", tag, i), got_writes[i][DATA_W-1:0],
                        exp_writes[i][DATA_W-1:0]);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        got_writes.delete();
        exp_writes.delete();
        exp_count = 0;
        exp_cur   = 0;
    endtask

    initial begin
        reset       = 1'b1;
        input_valid = 1'b0;
        input_value = '0;
        wr_ready    = 1'b0;
        tick();
        doReset();

        $display("[TB] reset state");
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_cur_addr", 32'(cur_addr), 32'd0);
        checkOutput("rst_count", 32'(write_count), 32'd0);
        checkOutput("rst_errs", {29'd0, err_range, err_overrun, err_timeout}, 32'd0);

        $display("[TB] single write");
        wr_ready = 1'b1;
        wr_en_cycles = 0;
        applyStimulus(32'h3);
        checkOutput("t1_phase_data", 32'(phase), 32'd1);
        checkOutput("t1_cur_addr", 32'(cur_addr), 32'd3);
        exp_cur = 3;
        applyStimulus(32'hDEADBEEF);
        modelWrite(32'hDEADBEEF);
        checkOutput("t1_wr_en_cycles", 32'(wr_en_cycles), 32'd1);
        checkOutput("t1_wr_en", 32'(wr_en), 32'd0);
        checkOutput("t1_count", 32'(write_count), 32'(exp_count));
        checkOutput("t1_phase", 32'(phase), 32'd1);
        checkOutput("t1_cur_addr_inc", 32'(cur_addr), 32'(exp_cur));
        checkWrites("t1");

        $display("[TB] timeout");
        wr_ready = 1'b0;
        wr_en_cycles = 0;
        d = $urandom;
        applyStimulus(d);
        waitWriteIdle(20);
        checkOutput("t4_wr_en_cycles", 32'(wr_en_cycles), 32'(WR_TIMEOUT));
        checkOutput("t4_err_timeout", 32'(err_timeout), 32'd1);
        checkOutput("t4_phase", 32'(phase), 32'd0);
        checkOutput("t4_count", 32'(write_count), 32'(exp_count));
        checkOutput("t4_cur_addr", 32'(cur_addr), 32'(exp_cur));
        checkWrites("t4");

        $display("[TB] address range");
        applyStimulus(32'h20);
        checkOutput("t3_err_range", 32'(err_range), 32'd1);
        checkOutput("t3_phase", 32'(phase), 32'd0);
        checkOutput("t3_cur_addr", 32'(cur_addr), 32'(exp_cur));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'($urandom_range(32'hFFFF_FFFF, 32'h20)));
            checkOutput($sformatf("t3_rand_phase%0d", i), 32'(phase), 32'd0);
            checkOutput($sformatf("t3_rand_cur%0d", i), 32'(cur_addr), 32'(exp_cur));
        end
        applyStimulus(32'h05);
        checkOutput("t3_phase_data", 32'(phase), 32'd1);
        checkOutput("t3_cur_addr5", 32'(cur_addr), 32'd5);

        $display("[TB] reset during write");
        wr_ready    = 1'b0;
        input_valid = 1'b1;
        input_value = $urandom;
        tick();
        checkOutput("t6_wr_en_rise", 32'(wr_en), 32'd1);
        input_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6_wr_en", 32'(wr_en), 32'd0);
        checkOutput("t6_phase", 32'(phase), 32'd0);
        checkOutput("t6_count", 32'(write_count), 32'd0);
        checkOutput("t6_cur_addr", 32'(cur_addr), 32'd0);
        checkOutput("t6_errs", {29'd0, err_range, err_overrun, err_timeout}, 32'd0);
        got_writes.delete();
        exp_writes.delete();
        exp_count = 0;
        exp_cur   = 0;
        tick();

        $display("[TB] burst with wrap");
        wr_ready = 1'b1;
        applyStimulus(32'h1E);
        exp_cur = 32'h1E;
        burst_vals[0] = 32'hA;
        burst_vals[1] = 32'hB;
        burst_vals[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(burst_vals[i]);
            modelWrite(burst_vals[i]);
        end
        checkOutput("t2_count", 32'(write_count), 32'd3);
        checkOutput("t2_cur_addr", 32'(cur_addr), 32'd1);
        checkWrites("t2");
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            applyStimulus(d);
            modelWrite(d);
        end
        checkOutput("t2r_count", 32'(write_count), 32'(exp_count));
        checkOutput("t2r_cur_addr", 32'(cur_addr), 32'(exp_cur));
        checkWrites("t2r");

        $display("[TB] held valid and overrun");
        wr_ready = 1'b0;
        applyStimulus($urandom);
        waitWriteIdle(20);
        checkOutput("t5_phase_addr", 32'(phase), 32'd0);
        wr_en_cycles = 0;
        input_valid  = 1'b1;
        input_value  = 32'h07;
        repeat (10) tick();
        input_valid = 1'b0;
        tick();
        checkOutput("t5_one_entry_phase", 32'(phase), 32'd1);
        checkOutput("t5_cur_addr", 32'(cur_addr), 32'd7);
        checkOutput("t5_no_write", 32'(wr_en_cycles), 32'd0);
        exp_cur = 7;
        d = $urandom;
        applyStimulus(d);
        applyStimulus(~d);
        checkOutput("t5_err_overrun", 32'(err_overrun), 32'd1);
        checkOutput("t5_wr_data", wr_data, d);
        checkOutput("t5_wr_addr", 32'(wr_addr), 32'd7);
        checkOutput("t5_wr_en", 32'(wr_en), 32'd1);
        waitWriteIdle(20);
        checkOutput("t5_count", 32'(write_count), 32'(exp_count));

        $display("[TB] ready coincident with dropped entry");
        applyStimulus(32'h09);
        exp_cur = 9;
        d2 = $urandom;
        applyStimulus(d2);
        input_valid = 1'b1;
        input_value = $urandom;
        wr_ready    = 1'b1;
        tick();
        input_valid = 1'b0;
        wr_ready    = 1'b0;
        modelWrite(d2);
        tick();
        checkOutput("t7_count", 32'(write_count), 32'(exp_count));
        checkOutput("t7_phase", 32'(phase), 32'd1);
        checkOutput("t7_cur_addr", 32'(cur_addr), 32'(exp_cur));
        checkOutput("t7_sticky", {29'd0, err_range, err_overrun, err_timeout}, 32'b011);
        checkWrites("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
